// File: rtl/uart_rx_8n1_sampler.sv
// rtl/uart_rx_8n1_sampler.sv - 8N1 UART receiver, 16x oversampled, valid/ready output with sticky overrun
module uart_rx_8n1_sampler #(
   parameter int CLK_HZ = 12_000_000,
   parameter int BAUD   = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int OVERSAMPLE = 16;
   localparam int DIV        = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int CW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]    s_q, s_d;
   logic [2:0]    b_q, b_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          rxs;
   logic          tick;
   logic          deliver;
   logic          accept;

   assign rxs       = sync2_q;
   assign tick      = (tick_cnt_q == DIV_M1);
   assign accept    = rx_valid_q & rx_ready;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

   // Next-state logic: synchronizer, sample tick, frame FSM and output handshake
   always_comb begin
      state_d     = state_q;
      sync1_d     = uart_rx;
      sync2_d     = sync1_q;
      tick_cnt_d  = tick ? '0 : tick_cnt_q + CW'(1);
      s_d         = s_q;
      b_d         = b_q;
      shreg_d     = shreg_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;
      deliver     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               // Realign sample phase to the detected start edge
               state_d    = S_START;
               s_d        = 4'd0;
               tick_cnt_d = '0;
            end
         end
         S_START: begin
            if (tick) begin
               if (s_q == 4'd7) begin
                  if (rxs) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     s_d     = 4'd0;
                     b_d     = 3'd0;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               s_d = s_q + 4'd1;
               if (s_q == 4'd15) begin
                  shreg_d[b_q] = rxs;
                  if (b_q == 3'd7) state_d = S_STOP;
                  else             b_d     = b_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               s_d = s_q + 4'd1;
               if (s_q == 4'd15) begin
                  if (rxs) begin
                     deliver = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = S_BREAK;
                  end
               end
            end
         end
         S_BREAK: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         rx_valid_d = 1'b0;
         overrun_d  = 1'b0;
      end
      if (deliver) begin
         if (!rx_valid_q || accept) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State registers with synchronous active-low reset; synchronizer resets to idle-high
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         tick_cnt_q  <= '0;
         s_q         <= 4'd0;
         b_q         <= 3'd0;
         shreg_q     <= 8'd0;
         rx_data_q   <= 8'd0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         tick_cnt_q  <= tick_cnt_d;
         s_q         <= s_d;
         b_q         <= b_d;
         shreg_q     <= shreg_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_8n1_sampler.sv
// tb/tb_uart_rx_8n1_sampler.sv - directed testbench for uart_rx_8n1_sampler
module tb_uart_rx_8n1_sampler;

   localparam int BIT_CLKS = 64;

   logic       clk;
   logic       rst_n;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   int vectors;
   int miscompares;
   int valid_hi_cnt;
   int acc_cnt;
   int ferr_cnt;
   logic [7:0] last_data;

   uart_rx_8n1_sampler #(
      .CLK_HZ(640_000),
      .BAUD  (10_000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .uart_rx  (uart_rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe outputs on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) valid_hi_cnt++;
         if (rx_valid && rx_ready) begin
            acc_cnt++;
            last_data = rx_data;
         end
         if (frame_err) ferr_cnt++;
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      valid_hi_cnt = 0;
      acc_cnt      = 0;
      ferr_cnt     = 0;
      last_data    = 8'h00;
   endtask

   task automatic send_bit(input logic v);
      uart_rx = v;
      wait_clks(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop_bit);
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      uart_rx  = 1'b0;
      rx_ready = 1'b0;
      wait_clks(3);
      vectors++;
      if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      vectors++;
      if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
      vectors++;
      if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
      uart_rx = 1'b1;
      rst_n   = 1'b1;
      clear_counts();
      wait_clks(100);
      vectors++;
      if (rx_valid !== 1'b0 || valid_hi_cnt != 0) begin
         miscompares++;
         $display("FAIL idle_after_reset rx_valid %b cycles %0d want 0/0", rx_valid, valid_hi_cnt);
      end
   endtask

   task automatic test_single_frame();
      clear_counts();
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1);
      wait_clks(16);
      vectors++;
      if (valid_hi_cnt != 1) begin miscompares++; $display("FAIL a5_valid_width got %0d want 1", valid_hi_cnt); end
      vectors++;
      if (acc_cnt != 1 || last_data !== 8'hA5) begin
         miscompares++;
         $display("FAIL a5_data got %h (accepts %0d) want a5 (1)", last_data, acc_cnt);
      end
      vectors++;
      if (ferr_cnt != 0) begin miscompares++; $display("FAIL a5_frame_err got %0d want 0", ferr_cnt); end
      vectors++;
      if (overrun !== 1'b0) begin miscompares++; $display("FAIL a5_overrun got %b want 0", overrun); end
   endtask

   task automatic test_false_start();
      clear_counts();
      rx_ready = 1'b1;
      uart_rx  = 1'b0;
      wait_clks(16);
      uart_rx  = 1'b1;
      wait_clks(200);
      vectors++;
      if (valid_hi_cnt != 0) begin miscompares++; $display("FAIL glitch_valid got %0d want 0", valid_hi_cnt); end
      vectors++;
      if (ferr_cnt != 0) begin miscompares++; $display("FAIL glitch_frame_err got %0d want 0", ferr_cnt); end
      send_frame(8'h5A, 1'b1);
      wait_clks(16);
      vectors++;
      if (acc_cnt != 1 || last_data !== 8'h5A) begin
         miscompares++;
         $display("FAIL after_glitch_data got %h (accepts %0d) want 5a (1)", last_data, acc_cnt);
      end
      vectors++;
      if (ferr_cnt != 0) begin miscompares++; $display("FAIL after_glitch_frame_err got %0d want 0", ferr_cnt); end
   endtask

   task automatic test_framing_error();
      clear_counts();
      rx_ready = 1'b1;
      send_frame(8'h3C, 1'b0);
      wait_clks(200);
      vectors++;
      if (ferr_cnt != 1) begin miscompares++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt); end
      vectors++;
      if (valid_hi_cnt != 0 || rx_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ferr_valid cycles %0d rx_valid %b want 0/0", valid_hi_cnt, rx_valid);
      end
      uart_rx = 1'b1;
      wait_clks(100);
      send_frame(8'h55, 1'b1);
      wait_clks(16);
      vectors++;
      if (acc_cnt != 1 || last_data !== 8'h55) begin
         miscompares++;
         $display("FAIL after_break_data got %h (accepts %0d) want 55 (1)", last_data, acc_cnt);
      end
      vectors++;
      if (ferr_cnt != 1) begin miscompares++; $display("FAIL after_break_ferr got %0d want 1", ferr_cnt); end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      wait_clks(16);
      vectors++;
      if (rx_data !== 8'h11) begin miscompares++; $display("FAIL ovr_data_held got %h want 11", rx_data); end
      vectors++;
      if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid got %b want 1", rx_valid); end
      vectors++;
      if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", overrun); end
      rx_ready = 1'b1;
      wait_clks(1);
      rx_ready = 1'b0;
      vectors++;
      if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL ovr_accept rx_valid %b overrun %b want 0/0", rx_valid, overrun);
      end
      vectors++;
      if (acc_cnt != 1 || last_data !== 8'h11) begin
         miscompares++;
         $display("FAIL ovr_accept_data got %h (accepts %0d) want 11 (1)", last_data, acc_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_counts();
      rx_ready = 1'b1;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      uart_rx = 1'b1;
      rst_n   = 1'b0;
      wait_clks(2);
      vectors++;
      if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_outputs data %h valid %b want 00/0", rx_data, rx_valid);
      end
      vectors++;
      if (frame_err !== 1'b0 || overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_flags ferr %b ovr %b want 0/0", frame_err, overrun);
      end
      rst_n = 1'b1;
      wait_clks(700);
      vectors++;
      if (valid_hi_cnt != 0 || ferr_cnt != 0) begin
         miscompares++;
         $display("FAIL midrst_no_delivery valid %0d ferr %0d want 0/0", valid_hi_cnt, ferr_cnt);
      end
      send_frame(8'hF0, 1'b1);
      wait_clks(16);
      vectors++;
      if (acc_cnt != 1 || last_data !== 8'hF0) begin
         miscompares++;
         $display("FAIL midrst_next_data got %h (accepts %0d) want f0 (1)", last_data, acc_cnt);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      clear_counts();
      rst_n    = 1'b0;
      uart_rx  = 1'b1;
      rx_ready = 1'b0;
      test_reset();
      test_single_frame();
      test_false_start();
      test_framing_error();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
